// File: rtl/axi_pmu_collector_if.sv
// AXI-Stream master/slave bundle carrying PMU readout frames (32-bit beats,
// tuser marks the header beat, tlast marks the final beat).
interface axi_pmu_collector_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axi_pmu_collector.sv
// Readout scheduler walking every counter of every PMU and streaming them as one AXIS frame.
// Optional PMU_COLLECT_TIMESTAMP_EN adds a 64-bit trigger timestamp after the header.
//
// state  | meaning
// IDLE   | waiting for start_i or periodic timer trigger
// HDR    | header beat {seq, NUM_PMUS, NUM_COUNTERS}, tuser=1
// TS_LO  | timestamp low word (PMU_COLLECT_TIMESTAMP_EN only)
// TS_HI  | timestamp high word (PMU_COLLECT_TIMESTAMP_EN only)
// SEL    | drive counter select, capture selected PMU value into data_q
// LO     | emit data_q[31:0]
// HI     | emit data_q[63:32], advance counter/PMU index
module axi_pmu_collector #(
    parameter int NUM_PMUS     = 4,
    parameter int NUM_COUNTERS = 19,
    parameter int PERIOD_WIDTH = 32
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      start_i,
    input  logic [PERIOD_WIDTH-1:0]   period_i,
    input  logic                      clear_i,
    output logic [4:0]                pmu_addr_o,
    input  logic [NUM_PMUS*64-1:0]    pmu_data_i,
    axi_pmu_collector_if.master       m,
    output logic                      busy_o,
    output logic                      overrun_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_SEL   = 3'd2,
        S_LO    = 3'd3,
`ifdef PMU_COLLECT_TIMESTAMP_EN
        S_HI    = 3'd4,
        S_TS_LO = 3'd5,
        S_TS_HI = 3'd6
`else
        S_HI    = 3'd4
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [PERIOD_WIDTH-1:0] timer_q;
    logic [15:0]             seq_q;
    logic [7:0]              pmu_idx_q;
    logic [4:0]              cnt_idx_q;
    logic [63:0]             data_q;
    logic [63:0]             sel_data;
    logic                    overrun_q;
    logic [31:0]             tdata_c;
    logic                    tvalid_c, tlast_c, tuser_c;
    logic                    timer_fire, trig, accept, hs, last_cnt, last_pmu;

    // >= rather than == so a period shrunk below the running count still fires promptly
    assign timer_fire = (period_i != '0) && (timer_q >= period_i - PERIOD_WIDTH'(1));
    assign trig       = start_i | timer_fire;
    assign accept     = trig && (state_q == S_IDLE);
    assign hs         = tvalid_c && m.tready;
    assign last_cnt   = (cnt_idx_q == 5'(NUM_COUNTERS - 1));
    assign last_pmu   = (pmu_idx_q == 8'(NUM_PMUS - 1));

`ifdef PMU_COLLECT_TIMESTAMP_EN
    logic [63:0] cyc_q, ts_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cyc_q <= '0;
            ts_q  <= '0;
        end else begin
            cyc_q <= cyc_q + 64'd1;
            if (accept) ts_q <= cyc_q;
        end
    end
`endif

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_PMUS; k++) begin
            if (pmu_idx_q == 8'(k)) sel_data = pmu_data_i[k*64 +: 64];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        tvalid_c = 1'b0;
        tdata_c  = '0;
        tlast_c  = 1'b0;
        tuser_c  = 1'b0;
        case (state_q)
            S_IDLE: if (trig) state_d = S_HDR;
            S_HDR: begin
                tvalid_c = 1'b1;
                tuser_c  = 1'b1;
                tdata_c  = {seq_q, 8'(NUM_PMUS), 8'(NUM_COUNTERS)};
`ifdef PMU_COLLECT_TIMESTAMP_EN
                if (hs) state_d = S_TS_LO;
`else
                if (hs) state_d = S_SEL;
`endif
            end
`ifdef PMU_COLLECT_TIMESTAMP_EN
            S_TS_LO: begin
                tvalid_c = 1'b1;
                tdata_c  = ts_q[31:0];
                if (hs) state_d = S_TS_HI;
            end
            S_TS_HI: begin
                tvalid_c = 1'b1;
                tdata_c  = ts_q[63:32];
                if (hs) state_d = S_SEL;
            end
`endif
            S_SEL: state_d = S_LO;
            S_LO: begin
                tvalid_c = 1'b1;
                tdata_c  = data_q[31:0];
                if (hs) state_d = S_HI;
            end
            S_HI: begin
                tvalid_c = 1'b1;
                tdata_c  = data_q[63:32];
                tlast_c  = last_cnt && last_pmu;
                if (hs) state_d = (last_cnt && last_pmu) ? S_IDLE : S_SEL;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            timer_q   <= '0;
            seq_q     <= '0;
            pmu_idx_q <= '0;
            cnt_idx_q <= '0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (period_i == '0 || timer_fire) timer_q <= '0;
            else                              timer_q <= timer_q + PERIOD_WIDTH'(1);

            if (trig && state_q != S_IDLE) overrun_q <= 1'b1;
            else if (clear_i)              overrun_q <= 1'b0;

            if (state_q == S_HDR && hs) seq_q <= seq_q + 16'd1;
            if (state_q == S_SEL)       data_q <= sel_data;

            if (state_q == S_HI && hs) begin
                if (last_cnt) begin
                    cnt_idx_q <= '0;
                    pmu_idx_q <= last_pmu ? 8'd0 : pmu_idx_q + 8'd1;
                end else begin
                    cnt_idx_q <= cnt_idx_q + 5'd1;
                end
            end
        end
    end

    // cnt_idx only moves on HI handshakes, so it already holds the last select outside SEL
    assign pmu_addr_o = (state_q == S_IDLE) ? 5'd0 : cnt_idx_q;
    assign busy_o     = (state_q != S_IDLE);
    assign overrun_o  = overrun_q;

    assign m.tdata  = tdata_c;
    assign m.tvalid = tvalid_c;
    assign m.tlast  = tlast_c;
    assign m.tuser  = tuser_c;

endmodule

// File: tb/tb_axi_pmu_collector.sv
// Self-checking bench for axi_pmu_collector (NUM_PMUS=2, NUM_COUNTERS=3); expected
// frames are rebuilt from the frame layout and the PMU values present at each SEL cycle.
`timescale 1ns/1ps
module tb_axi_pmu_collector;
    localparam int NP = 2;
    localparam int NC = 3;
    localparam int PW = 32;
`ifdef PMU_COLLECT_TIMESTAMP_EN
    localparam int TSB = 2;
`else
    localparam int TSB = 0;
`endif
    localparam int FRAME = 1 + TSB + 2*NP*NC;
    localparam int HN = 4096;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              start_i = 1'b0;
    logic              clear_i = 1'b0;
    logic [PW-1:0]     period_i = '0;
    logic [4:0]        pmu_addr_o;
    logic [NP*64-1:0]  pmu_data_i;
    logic              busy_o, overrun_o;

    axi_pmu_collector_if m_if();

    axi_pmu_collector #(.NUM_PMUS(NP), .NUM_COUNTERS(NC), .PERIOD_WIDTH(PW)) dut (
        .aclk(aclk), .aresetn(aresetn), .start_i(start_i), .period_i(period_i),
        .clear_i(clear_i), .pmu_addr_o(pmu_addr_o), .pmu_data_i(pmu_data_i),
        .m(m_if.master), .busy_o(busy_o), .overrun_o(overrun_o)
    );

    always #5 aclk = ~aclk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    logic [63:0] run_cyc;
    logic [63:0] salt_hist [HN];
    logic [63:0] cur_salt;
    logic        salt_en = 1'b0;
    logic [15:0] exp_seq = '0;
    logic [63:0] exp_ts = '0;

    logic [31:0] bd[$];
    bit          bl[$];
    bit          bu[$];
    int unsigned bc[$];
    int          stall_err;

    always @(posedge aclk) begin
        cyc <= cyc + 1;
        salt_hist[(cyc + 1) % HN] <= salt_en ? {$urandom, $urandom} : 64'h0;
    end

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) run_cyc <= '0;
        else          run_cyc <= run_cyc + 64'd1;
    end

    assign cur_salt = salt_hist[cyc % HN];

    function automatic logic [63:0] base_val(int k, int a);
        return {16'hBE00 | 16'(k), 16'(a), 16'(k * 257), 16'(a * 257 + 1)};
    endfunction

    always_comb begin
        pmu_data_i = '0;
        for (int k = 0; k < NP; k++)
            pmu_data_i[k*64 +: 64] = base_val(k, int'(pmu_addr_o)) ^ cur_salt;
    end

    // Beat i of a frame: the PMU value for a LO/HI pair is whatever the PMUs showed in
    // the cycle right after the handshake of the beat preceding that LO.
    function automatic logic [33:0] exp_beat(int i, logic [15:0] seq, logic [63:0] ts);
        logic [31:0] d;
        logic [63:0] v;
        int j, p;
        if (i == 0) d = {seq, 8'(NP), 8'(NC)};
        else if (i <= TSB) d = (i == 1) ? ts[31:0] : ts[63:32];
        else begin
            j = i - 1 - TSB;
            p = j / 2;
            v = base_val(p / NC, p % NC) ^ salt_hist[(bc[i - 1 - (j % 2)] + 1) % HN];
            d = (j % 2 == 1) ? v[63:32] : v[31:0];
        end
        return {i == 0, i == FRAME - 1, d};
    endfunction

    task automatic collect_frame(input int pct, input int start_at, input bit clr_too,
                                 output bit timed_out);
        bit          prev_stall = 0;
        bit          done = 0;
        bit          fired = 0;
        logic [34:0] prev = '0;
        bd.delete(); bl.delete(); bu.delete(); bc.delete();
        stall_err = 0;
        timed_out = 0;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge aclk);
            start_i = 1'b0;
            clear_i = 1'b0;
            if (prev_stall && {m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata} !== prev)
                stall_err++;
            m_if.tready = ($urandom_range(99) < pct);
            if (start_at >= 0 && !fired && bd.size() == start_at) begin
                start_i = 1'b1;
                clear_i = clr_too;
                fired = 1;
            end
            if (m_if.tvalid && m_if.tready) begin
                bd.push_back(m_if.tdata);
                bl.push_back(m_if.tlast);
                bu.push_back(m_if.tuser);
                bc.push_back(cyc);
                if (m_if.tlast) done = 1;
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev = {m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata};
        end
        timed_out = !done;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge aclk);
        checks++;
        if ({m_if.tvalid, m_if.tlast, m_if.tuser, busy_o, overrun_o} !== 5'b0 ||
            m_if.tdata !== 32'h0 || pmu_addr_o !== 5'h0) begin
            errors++;
            $display("FAIL reset_outputs got v%b l%b u%b busy%b ovr%b d%h a%h want all 0",
                     m_if.tvalid, m_if.tlast, m_if.tuser, busy_o, overrun_o, m_if.tdata, pmu_addr_o);
        end
        aresetn = 1'b1;
        @(negedge aclk);
        checks++;
        if (busy_o !== 1'b0 || m_if.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got busy%b v%b want 0 0", busy_o, m_if.tvalid);
        end
    endtask

    task automatic test_single_frame();
        bit to;
        int unsigned scyc;
        logic [33:0] got, exp;
        start_i = 1'b1;
        scyc = cyc;
        collect_frame(100, -1, 0, to);
        checks++;
        if (to || bd.size() != FRAME) begin
            errors++;
            $display("FAIL single_len got %0d beats (timeout %0d) want %0d", bd.size(), to, FRAME);
        end
        checks++;
        if (bd.size() > 0 && bc[0] != scyc + 1) begin
            errors++;
            $display("FAIL single_latency got cycle %0d want %0d", bc[0], scyc + 1);
        end
        for (int i = 0; i < bd.size() && i < FRAME; i++) begin
            checks++;
            got = {bu[i], bl[i], bd[i]};
            exp = exp_beat(i, exp_seq, exp_ts);
            if (got !== exp) begin
                errors++;
                $display("FAIL single_beat%0d got %h want %h", i, got, exp);
            end
        end
        exp_seq++;
        repeat (2) @(negedge aclk);
        checks++;
        if (busy_o !== 1'b0 || pmu_addr_o !== 5'd0) begin
            errors++;
            $display("FAIL single_idle got busy%b addr%0d want 0 0", busy_o, pmu_addr_o);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        logic [33:0] got, exp;
        salt_en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            @(negedge aclk);
            start_i = 1'b1;
            collect_frame(50, -1, 0, to);
            checks++;
            if (to || bd.size() != FRAME || stall_err != 0) begin
                errors++;
                $display("FAIL bp_frame%0d got %0d beats stall_err %0d timeout %0d want %0d 0 0",
                         f, bd.size(), stall_err, to, FRAME);
            end
            for (int i = 0; i < bd.size() && i < FRAME; i++) begin
                checks++;
                got = {bu[i], bl[i], bd[i]};
                exp = exp_beat(i, exp_seq, exp_ts);
                if (got !== exp) begin
                    errors++;
                    $display("FAIL bp_f%0d_beat%0d got %h want %h", f, i, got, exp);
                end
            end
            exp_seq++;
        end
        salt_en = 1'b0;
        repeat (3) @(negedge aclk);
    endtask

    task automatic test_timer();
        bit to;
        int unsigned hdr_cyc[3];
        logic [33:0] got, exp;
        @(negedge aclk);
        period_i = 200;
        for (int f = 0; f < 3; f++) begin
            collect_frame(100, -1, 0, to);
            if (f == 2) period_i = '0;
            checks++;
            if (to || bd.size() != FRAME) begin
                errors++;
                $display("FAIL timer_frame%0d got %0d beats timeout %0d want %0d", f, bd.size(), to, FRAME);
            end
            hdr_cyc[f] = (bd.size() > 0) ? bc[0] : 0;
            for (int i = 0; i < bd.size() && i < FRAME; i++) begin
                checks++;
                got = {bu[i], bl[i], bd[i]};
                exp = exp_beat(i, exp_seq, exp_ts);
                if (got !== exp) begin
                    errors++;
                    $display("FAIL timer_f%0d_beat%0d got %h want %h", f, i, got, exp);
                end
            end
            exp_seq++;
        end
        for (int f = 1; f < 3; f++) begin
            checks++;
            if (hdr_cyc[f] - hdr_cyc[f-1] != 200) begin
                errors++;
                $display("FAIL timer_spacing%0d got %0d want 200", f, hdr_cyc[f] - hdr_cyc[f-1]);
            end
        end
        repeat (250) @(negedge aclk);
        checks++;
        if (overrun_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL timer_quiet got ovr%b busy%b want 0 0", overrun_o, busy_o);
        end
    endtask

    task automatic test_overrun();
        bit to;
        logic [33:0] got, exp;
        @(negedge aclk);
        period_i = 10;
        collect_frame(100, -1, 0, to);
        period_i = '0;
        checks++;
        if (to || bd.size() != FRAME) begin
            errors++;
            $display("FAIL ovr_timer_len got %0d beats timeout %0d want %0d", bd.size(), to, FRAME);
        end
        for (int i = 0; i < bd.size() && i < FRAME; i++) begin
            checks++;
            got = {bu[i], bl[i], bd[i]};
            exp = exp_beat(i, exp_seq, exp_ts);
            if (got !== exp) begin
                errors++;
                $display("FAIL ovr_timer_beat%0d got %h want %h", i, got, exp);
            end
        end
        exp_seq++;
        repeat (20) @(negedge aclk);
        checks++;
        if (overrun_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL ovr_sticky got ovr%b busy%b want 1 0", overrun_o, busy_o);
        end
        clear_i = 1'b1;
        @(negedge aclk);
        clear_i = 1'b0;
        checks++;
        if (overrun_o !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear got %b want 0", overrun_o);
        end
        // start during a frame together with clear: the drop must still register
        start_i = 1'b1;
        collect_frame(100, 5, 1, to);
        checks++;
        if (to || bd.size() != FRAME) begin
            errors++;
            $display("FAIL ovr_mid_len got %0d beats timeout %0d want %0d", bd.size(), to, FRAME);
        end
        for (int i = 0; i < bd.size() && i < FRAME; i++) begin
            checks++;
            got = {bu[i], bl[i], bd[i]};
            exp = exp_beat(i, exp_seq, exp_ts);
            if (got !== exp) begin
                errors++;
                $display("FAIL ovr_mid_beat%0d got %h want %h", i, got, exp);
            end
        end
        exp_seq++;
        repeat (20) @(negedge aclk);
        checks++;
        if (overrun_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL ovr_set_wins got ovr%b busy%b want 1 0", overrun_o, busy_o);
        end
        clear_i = 1'b1;
        @(negedge aclk);
        clear_i = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        bit to;
        bit hit = 0;
        int n = 0;
        logic [33:0] got, exp;
        start_i = 1'b1;
        for (int t = 0; t < 100 && !hit; t++) begin
            @(negedge aclk);
            start_i = 1'b0;
            m_if.tready = 1'b1;
            if (n == 6 && m_if.tvalid) hit = 1;
            else if (m_if.tvalid) n++;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rstmid_reach got %0d beats want 6 before beat 7", n);
        end
        aresetn = 1'b0;
        #1;
        checks++;
        if (m_if.tvalid !== 1'b0 || busy_o !== 1'b0 || pmu_addr_o !== 5'd0) begin
            errors++;
            $display("FAIL rstmid_async got v%b busy%b addr%0d want 0 0 0", m_if.tvalid, busy_o, pmu_addr_o);
        end
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        exp_seq = '0;
        @(negedge aclk);
        start_i = 1'b1;
        collect_frame(100, -1, 0, to);
        checks++;
        if (to || bd.size() != FRAME) begin
            errors++;
            $display("FAIL rstmid_len got %0d beats timeout %0d want %0d", bd.size(), to, FRAME);
        end
        for (int i = 0; i < bd.size() && i < FRAME; i++) begin
            checks++;
            got = {bu[i], bl[i], bd[i]};
            exp = exp_beat(i, exp_seq, exp_ts);
            if (got !== exp) begin
                errors++;
                $display("FAIL rstmid_beat%0d got %h want %h", i, got, exp);
            end
        end
        exp_seq++;
        repeat (3) @(negedge aclk);
    endtask

    task automatic test_timestamp();
        bit to;
        logic [33:0] got, exp;
        @(negedge aclk);
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        exp_seq = '0;
        for (int t = 0; t < 200 && run_cyc != 64'd100; t++) @(negedge aclk);
        start_i = 1'b1;
        exp_ts = run_cyc;
        checks++;
        if (exp_ts != 64'd100) begin
            errors++;
            $display("FAIL ts_setup got cycle %0d want 100", exp_ts);
        end
        collect_frame(100, -1, 0, to);
        checks++;
        if (to || bd.size() != FRAME) begin
            errors++;
            $display("FAIL ts_len got %0d beats timeout %0d want %0d", bd.size(), to, FRAME);
        end
        for (int i = 0; i < bd.size() && i < FRAME; i++) begin
            checks++;
            got = {bu[i], bl[i], bd[i]};
            exp = exp_beat(i, exp_seq, exp_ts);
            if (got !== exp) begin
                errors++;
                $display("FAIL ts_beat%0d got %h want %h", i, got, exp);
            end
        end
        exp_seq++;
        repeat (3) @(negedge aclk);
    endtask

    initial begin
        for (int i = 0; i < HN; i++) salt_hist[i] = 64'h0;
        m_if.tready = 1'b0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_timer();
        test_overrun();
        test_reset_mid_frame();
        test_timestamp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
